// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch/PC controller.
// State encoding, pc_sel codes and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_BUF  = 2'b11
  } fetch_state_e;

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_JAL  = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;
  localparam logic [1:0] SEL_BR   = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_pc_ctrl_pc_target_calc.sv
// Combinational redirect target from the pc_sel encoding.
// All sums wrap modulo 2^ADDR_W.
module pc_target_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        sel,
  input  logic              jump,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] base_adr,
  output logic [ADDR_W-1:0] target
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] pc_plus_inc;
  logic [ADDR_W-1:0] pc_plus_imm;

  assign pc_plus_inc = pc + INC;
  assign pc_plus_imm = pc + imm;

  always_comb begin
    target = pc_plus_inc;
    unique case (sel)
      SEL_PC4:  target = pc_plus_inc;
      SEL_JAL:  target = pc_plus_imm;
      SEL_JALR: target = base_adr + imm;
      SEL_BR:   target = jump ? pc_plus_imm : pc_plus_inc;
      default:  target = pc_plus_inc;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Instruction fetch sequencer: owns the PC, one outstanding imem request,
// one buffered instruction for decode, redirects from execute.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | one cycle after reset; latch first fetch address
// ST_REQ  | imem_req high at req_addr_q until granted
// ST_WAIT | request granted, waiting for imem_rvalid
// ST_BUF  | instruction held for decode until consumed or redirected
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic              redirect_jump,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc4
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              squash_q, squash_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] target;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_pc_target_calc (
    .sel      (redirect_sel),
    .jump     (redirect_jump),
    .pc       (redirect_pc),
    .imm      (imm),
    .base_adr (base_adr),
    .target   (target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;

    if (redirect_valid) pc_d = target;

    unique case (state_q)
      ST_IDLE: begin
        req_addr_d = redirect_valid ? target : pc_q;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        // The address already on the bus stays; its response gets dropped.
        if (redirect_valid) squash_d = 1'b1;
        if (imem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (squash_q || redirect_valid) begin
            squash_d   = 1'b0;
            req_addr_d = redirect_valid ? target : pc_q;
            state_d    = ST_REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = req_addr_q;
            pc_d      = req_addr_q + INC;
            state_d   = ST_BUF;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      ST_BUF: begin
        if (redirect_valid) begin
          req_addr_d = target;
          state_d    = ST_REQ;
        end else if (!stall) begin
          req_addr_d = pc_q;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      squash_q   <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      squash_q   <= squash_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = req_addr_q;
  assign inst_valid = (state_q == ST_BUF);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc_q + INC;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: hand sequences for fetch, stall,
// squash and reset, then a redirect-target vector table applied from BUF.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_sel = 2'b00;
  logic        redirect_jump = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] base_adr = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = '0;

  int checks = 0;
  int failures = 0;

  fetch_pc_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .redirect_jump  (redirect_jump),
    .redirect_pc    (redirect_pc),
    .imm            (imm),
    .base_adr       (base_adr),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] md(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: grant while enabled, respond once rsp_en allows (>=1 cycle later).
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = resp_pend & rsp_en;
  assign imem_rdata  = md(resp_addr);

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      resp_pend <= 1'b1;
      resp_addr <= imem_addr;
    end else if (imem_rvalid) begin
      resp_pend <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic set_redirect(input logic [1:0] sel, input logic jump,
                              input logic [31:0] rpc, input logic [31:0] im,
                              input logic [31:0] base);
    redirect_valid = 1'b1;
    redirect_sel   = sel;
    redirect_jump  = jump;
    redirect_pc    = rpc;
    imm            = im;
    base_adr       = base;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic        jump;
    logic [31:0] rpc;
    logic [31:0] im;
    logic [31:0] base;
    logic        stl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"pc4",        2'b00, 1'b0, 32'h0000_0100, 32'h0000_0040, 32'h0,         1'b0, 32'h0000_0104};
    vecs[1] = '{"jal",        2'b01, 1'b0, 32'h0000_0010, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0110};
    vecs[2] = '{"jalr",       2'b10, 1'b1, 32'h0000_0800, 32'h0000_0004, 32'h0000_0400, 1'b0, 32'h0000_0404};
    vecs[3] = '{"br_nt",      2'b11, 1'b0, 32'h0000_0020, 32'hFFFF_FFF0, 32'h0,         1'b0, 32'h0000_0024};
    vecs[4] = '{"br_t",       2'b11, 1'b1, 32'h0000_0020, 32'hFFFF_FFF0, 32'h0,         1'b1, 32'h0000_0010};
    vecs[5] = '{"jal_wrap",   2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0004};
    vecs[6] = '{"jalr_wrap",  2'b10, 1'b0, 32'h0,         32'h0000_0020, 32'hFFFF_FFF0, 1'b0, 32'h0000_0010};
    vecs[7] = '{"br_nt_wrap", 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0000};

    // reset state
    tick();
    tick();
    chk("rst_req",        {31'b0, imem_req},   32'd0);
    chk("rst_valid",      {31'b0, inst_valid}, 32'd0);
    chk("rst_inst",       inst,                32'd0);
    chk("rst_inst_pc",    inst_pc,             32'd0);

    // sequential fetch: REQ, WAIT, BUF repeating from 0x0
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("seq_req_c%0d", k), {31'b0, imem_req}, {31'b0, (k % 3) == 1});
      chk($sformatf("seq_valid_c%0d", k), {31'b0, inst_valid}, {31'b0, (k % 3) == 0});
      if ((k % 3) == 1) chk($sformatf("seq_addr_c%0d", k), imem_addr, 32'((k - 1) / 3 * 4));
      if ((k % 3) == 0) begin
        chk($sformatf("seq_pc_c%0d", k), inst_pc, 32'((k / 3 - 1) * 4));
        chk($sformatf("seq_inst_c%0d", k), inst, md(32'((k / 3 - 1) * 4)));
      end
    end

    // stall hold in BUF at 0x8
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_pc",    inst_pc,             32'h8);
      chk("stall_inst",  inst,                md(32'h8));
      chk("stall_req",   {31'b0, imem_req},   32'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_req",  {31'b0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr,         32'hC);

    // redirect in WAIT coinciding with rvalid
    tick();
    chk("wait_req", {31'b0, imem_req}, 32'd0);
    set_redirect(2'b01, 1'b0, 32'h10, 32'h100, 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("rdw_req",   {31'b0, imem_req},   32'd1);
    chk("rdw_addr",  imem_addr,           32'h110);
    chk("rdw_valid", {31'b0, inst_valid}, 32'd0);

    // redirect in WAIT before the response, response arrives later
    rsp_en = 1'b0;
    tick();
    set_redirect(2'b00, 1'b0, 32'h200, 32'h0, 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("rdw2_req",   {31'b0, imem_req},   32'd0);
    chk("rdw2_valid", {31'b0, inst_valid}, 32'd0);
    rsp_en = 1'b1;
    tick();
    chk("rdw2_valid_after", {31'b0, inst_valid}, 32'd0);
    chk("rdw2_addr",        imem_addr,           32'h204);
    chk("rdw2_req_after",   {31'b0, imem_req},   32'd1);

    // redirect in REQ with grant withheld for 3 cycles
    gnt_en = 1'b0;
    set_redirect(2'b10, 1'b0, 32'h0, 32'h4, 32'h400);
    for (int k = 0; k < 3; k++) begin
      tick();
      redirect_valid = 1'b0;
      chk("rdr_req",  {31'b0, imem_req}, 32'd1);
      chk("rdr_addr", imem_addr,         32'h204);
    end
    gnt_en = 1'b1;
    tick();
    chk("rdr_wait", {31'b0, imem_req}, 32'd0);
    tick();
    chk("rdr_drop_valid", {31'b0, inst_valid}, 32'd0);
    chk("rdr_next_addr",  imem_addr,           32'h404);
    wait_valid("rdr_fetch_valid");
    chk("rdr_fetch_pc",   inst_pc, 32'h404);
    chk("rdr_fetch_inst", inst,    md(32'h404));

    // reset asserted mid-WAIT; late response lands in IDLE
    tick();
    chk("pre_rst_addr", imem_addr, 32'h408);
    tick();
    rsp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mrst_req",     {31'b0, imem_req},   32'd0);
    chk("mrst_valid",   {31'b0, inst_valid}, 32'd0);
    chk("mrst_inst",    inst,                32'd0);
    chk("mrst_inst_pc", inst_pc,             32'd0);
    chk("mrst_addr",    imem_addr,           32'd0);
    tick();
    @(negedge clk);
    rst_n  = 1'b1;
    rsp_en = 1'b1;
    tick();
    chk("late_rv_req",   {31'b0, imem_req},   32'd1);
    chk("late_rv_addr",  imem_addr,           32'd0);
    chk("late_rv_valid", {31'b0, inst_valid}, 32'd0);
    wait_valid("late_rv_fetch_valid");
    chk("late_rv_pc",   inst_pc, 32'd0);
    chk("late_rv_inst", inst,    md(32'd0));

    // redirect target table, each redirect applied while in BUF
    for (int i = 0; i < 8; i++) begin
      stall = vecs[i].stl;
      set_redirect(vecs[i].sel, vecs[i].jump, vecs[i].rpc, vecs[i].im, vecs[i].base);
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      chk({vecs[i].name, "_req"},   {31'b0, imem_req},   32'd1);
      chk({vecs[i].name, "_addr"},  imem_addr,           vecs[i].exp);
      chk({vecs[i].name, "_valid"}, {31'b0, inst_valid}, 32'd0);
      wait_valid({vecs[i].name, "_fetch"});
      chk({vecs[i].name, "_pc"},   inst_pc,  vecs[i].exp);
      chk({vecs[i].name, "_pc4"},  inst_pc4, vecs[i].exp + 32'd4);
      chk({vecs[i].name, "_inst"}, inst,     md(vecs[i].exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
